// File: rtl/jtframe_joy_serial_tx.sv
// 74HC165-style joystick chain emulator: captures two players' buttons and shifts
// them out MSB-first on oversampled JOY_CLK rises, with JOY_LOAD as parallel load.
module jtframe_joy_serial_tx #(
  parameter int unsigned LEAD_BITS = 1,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [11:0] joy1_btn,
  input  logic [11:0] joy2_btn,
  input  logic        JOY_CLK,
  input  logic        JOY_LOAD,
  output logic        JOY_DATA,
  output logic        frame_done,
  output logic        restart_err
);

  localparam int unsigned FRAME_BITS = LEAD_BITS + 24;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int unsigned TO_W       = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOADING,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t                  state, state_n;
  logic [FRAME_BITS-1:0]   sreg, sreg_n;
  logic [FRAME_BITS-1:0]   frame_word;
  logic [23:0]             w;
  logic [CNT_W-1:0]        bit_cnt, cnt_n;
  logic [TO_W-1:0]         to_cnt, to_n;
  logic                    done_n, err_n;

  logic [2:0]              clk_sr, ld_sr;
  logic                    ld_s, ld_fall, clk_rise;

  // Synchronisers idle high so reset release never creates a phantom edge
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      clk_sr <= '1;
      ld_sr  <= '1;
    end else begin
      clk_sr <= {clk_sr[1:0], JOY_CLK};
      ld_sr  <= {ld_sr[1:0], JOY_LOAD};
    end
  end

  assign ld_s     = ld_sr[1];
  assign ld_fall  = ld_sr[2] & ~ld_sr[1];
  assign clk_rise = clk_sr[1] & ~clk_sr[2];

  assign w = {joy1_btn[8], joy1_btn[6], joy1_btn[5], joy1_btn[4],
              joy1_btn[0], joy1_btn[1], joy1_btn[2], joy1_btn[3],
              joy2_btn[8], joy2_btn[6], joy2_btn[5], joy2_btn[4],
              joy2_btn[0], joy2_btn[1], joy2_btn[2], joy2_btn[3],
              joy2_btn[10], joy2_btn[11], joy2_btn[9], joy2_btn[7],
              joy1_btn[10], joy1_btn[11], joy1_btn[9], joy1_btn[7]};

  // Lead bits sit above the 24 active-low button bits
  always_comb begin
    frame_word       = '1;
    frame_word[23:0] = ~w;
  end

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = bit_cnt;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!ld_s) begin
          state_n = ST_LOADING;
          sreg_n  = frame_word;
        end
      end
      ST_LOADING: begin
        if (ld_s) begin
          state_n = ST_SHIFT;
          cnt_n   = '0;
        end else begin
          sreg_n = frame_word;
        end
      end
      ST_SHIFT: begin
        // Load has priority over a coincident shift
        if (!ld_s) begin
          state_n = ST_LOADING;
          sreg_n  = frame_word;
          cnt_n   = '0;
          err_n   = ld_fall && (bit_cnt != '0);
        end else if (clk_rise) begin
          sreg_n = {sreg[FRAME_BITS-2:0], 1'b1};
          cnt_n  = bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
            state_n = ST_DONE;
            done_n  = 1'b1;
          end
        end else if (to_cnt >= TO_W'(TIMEOUT - 1)) begin
          state_n = ST_IDLE;
          sreg_n  = '1;
        end
      end
      ST_DONE: begin
        if (!ld_s) begin
          state_n = ST_LOADING;
          sreg_n  = frame_word;
        end else if (clk_rise) begin
          sreg_n = {sreg[FRAME_BITS-2:0], 1'b1};
        end
      end
      default: begin
        state_n = ST_IDLE;
        sreg_n  = '1;
      end
    endcase

    if (clk_rise || (state_n != state)) begin
      to_n = '0;
    end else if (to_cnt < TO_W'(TIMEOUT)) begin
      to_n = to_cnt + TO_W'(1);
    end else begin
      to_n = to_cnt;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      sreg        <= '1;
      bit_cnt     <= '0;
      to_cnt      <= '0;
      frame_done  <= 1'b0;
      restart_err <= 1'b0;
    end else begin
      state       <= state_n;
      sreg        <= sreg_n;
      bit_cnt     <= cnt_n;
      to_cnt      <= to_n;
      frame_done  <= done_n;
      restart_err <= err_n;
    end
  end

  assign JOY_DATA = sreg[FRAME_BITS-1];

endmodule
